// File: rtl/mem_iq_pkg.sv
// Shared definitions for the memory issue queue: opcodes, entry payload, operand-requirement helper.
package mem_iq_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Per-entry payload that does not take part in wakeup. The destination tag and the
  // two operand slots (value/ready/tag) sit beside it because their width follows the
  // WIDTH_REG parameter of the queue, and the operand slots live in mem_iq_operand.
  typedef struct packed {
    logic [6:0]        uop;
    logic [9:0]        func;
    logic [DATA_W-1:0] imm;
  } iq_payload_t;

  // Stores need the address base and the store data; everything else needs op1 only.
  function automatic logic needs_op2(input logic [6:0] uop);
    return uop == OPC_STORE;
  endfunction

endpackage

// File: rtl/mem_iq_operand.sv
// One operand slot of an issue-queue entry: holds value/ready/tag and snoops the writeback bus.
// With MEM_IQ_BYPASS_EN defined the slot also reports a same-cycle wakeup hit for bypass issue.
module mem_iq_operand
  import mem_iq_pkg::*;
#(
  parameter int WIDTH_REG = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_load,
  input  logic                 i_entry_valid,
  input  logic                 i_rdy,
  input  logic [WIDTH_REG-1:0] i_tag,
  input  logic [DATA_W-1:0]    i_val,
  input  logic                 i_wb_valid,
  input  logic [WIDTH_REG-1:0] i_wb_addr,
  input  logic [DATA_W-1:0]    i_wb_data,
  output logic                 o_rdy,
  output logic [DATA_W-1:0]    o_val
`ifdef MEM_IQ_BYPASS_EN
  ,
  output logic                 o_wake
`endif
);

  logic                 rdy_reg;
  logic [DATA_W-1:0]    val_reg;
  logic [WIDTH_REG-1:0] tag_reg;
  logic                 wb_live;
  logic                 wake_in;
  logic                 wake_hit;

  // Tag 0 is the hardwired zero register and never produces a wakeup.
  assign wb_live  = i_wb_valid && (i_wb_addr != '0);
  // Operand arriving this cycle whose producer is writing back right now.
  assign wake_in  = wb_live && !i_rdy && (i_tag == i_wb_addr);
  // Resident operand whose producer is writing back right now.
  assign wake_hit = wb_live && i_entry_valid && !rdy_reg && (tag_reg == i_wb_addr);

  // Slot state: load at enqueue (snooping the bus at the same time), else capture a wakeup.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdy_reg <= 1'b0;
      val_reg <= '0;
      tag_reg <= '0;
    end else if (!i_flush) begin
      if (i_load) begin
        rdy_reg <= i_rdy || wake_in;
        val_reg <= wake_in ? i_wb_data : i_val;
        tag_reg <= i_tag;
      end else if (wake_hit) begin
        rdy_reg <= 1'b1;
        val_reg <= i_wb_data;
      end
    end
  end

  assign o_rdy = rdy_reg;
  assign o_val = val_reg;
`ifdef MEM_IQ_BYPASS_EN
  assign o_wake = wake_hit;
`endif

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue between dispatch and the memory calculation unit.
// Circular buffer of 2^DEPTH_W entries; the oldest entry issues once its operands are ready.
// Optional macro MEM_IQ_BYPASS_EN: head operands may be taken straight off the writeback bus
// for same-cycle issue (adds a combinational wb -> o_* path). Undefined: all outputs registered-only.
module mem_issue_queue
  import mem_iq_pkg::*;
#(
  parameter int DEPTH_W   = 3,
  parameter int WIDTH_REG = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [6:0]           i_uop,
  input  logic [9:0]           i_func,
  input  logic [WIDTH_REG-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_imm,
  input  logic                 i_op1_rdy,
  input  logic                 i_op2_rdy,
  input  logic [WIDTH_REG-1:0] i_op1_tag,
  input  logic [WIDTH_REG-1:0] i_op2_tag,
  input  logic [DATA_W-1:0]    i_op1,
  input  logic [DATA_W-1:0]    i_op2,
  input  logic                 i_wb_valid,
  input  logic [WIDTH_REG-1:0] i_wb_addr,
  input  logic [DATA_W-1:0]    i_wb_data,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [6:0]           o_uop,
  output logic [9:0]           o_func,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic [DATA_W-1:0]    o_op1,
  output logic [DATA_W-1:0]    o_op2,
  output logic [DATA_W-1:0]    o_imm
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_COUNT = (DEPTH_W + 1)'(DEPTH);

  logic [DEPTH_W-1:0] head_reg, head_next;
  logic [DEPTH_W-1:0] tail_reg, tail_next;
  logic [DEPTH_W:0]   count_reg, count_next;
  logic [DEPTH-1:0]   valid_reg, valid_next;

  iq_payload_t          payload_reg [DEPTH];
  logic [WIDTH_REG-1:0] rd_reg      [DEPTH];

  logic [DEPTH-1:0]  entry_load;
  logic [DEPTH-1:0]  op1_rdy, op2_rdy;
  logic [DATA_W-1:0] op1_val [DEPTH];
  logic [DATA_W-1:0] op2_val [DEPTH];
`ifdef MEM_IQ_BYPASS_EN
  logic [DEPTH-1:0]  op1_wake, op2_wake;
`endif

  logic              full;
  logic              enq_fire;
  logic              pop_fire;
  logic              issue;
  logic              op1_ok, op2_ok;
  logic [DATA_W-1:0] op1_out, op2_out;
  iq_payload_t       head_payload;

  // No pop-push pass-through when full: o_ready depends on the count alone.
  assign full     = (count_reg == FULL_COUNT);
  assign o_ready  = !full;
  assign enq_fire = i_valid && !full && !i_flush;
  assign pop_fire = issue && !i_flush;

  // Per-entry storage: payload registers plus two operand slots with wakeup snooping.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_load[gi] = enq_fire && (tail_reg == DEPTH_W'(gi));

      // Payload written at enqueue; cleared on reset so idle outputs read 0.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          payload_reg[gi] <= '0;
          rd_reg[gi]      <= '0;
        end else if (entry_load[gi]) begin
          payload_reg[gi] <= '{uop: i_uop, func: i_func, imm: i_imm};
          rd_reg[gi]      <= i_addr;
        end
      end

      mem_iq_operand #(.WIDTH_REG(WIDTH_REG)) u_op1 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_load       (entry_load[gi]),
        .i_entry_valid(valid_reg[gi]),
        .i_rdy        (i_op1_rdy),
        .i_tag        (i_op1_tag),
        .i_val        (i_op1),
        .i_wb_valid   (i_wb_valid),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_rdy        (op1_rdy[gi]),
        .o_val        (op1_val[gi])
`ifdef MEM_IQ_BYPASS_EN
        ,
        .o_wake       (op1_wake[gi])
`endif
      );

      mem_iq_operand #(.WIDTH_REG(WIDTH_REG)) u_op2 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_load       (entry_load[gi]),
        .i_entry_valid(valid_reg[gi]),
        .i_rdy        (i_op2_rdy),
        .i_tag        (i_op2_tag),
        .i_val        (i_op2),
        .i_wb_valid   (i_wb_valid),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_rdy        (op2_rdy[gi]),
        .o_val        (op2_val[gi])
`ifdef MEM_IQ_BYPASS_EN
        ,
        .o_wake       (op2_wake[gi])
`endif
      );
    end
  endgenerate

  // Head readiness and operand selection; only the head may issue (strict program order).
  always_comb begin
    head_payload = payload_reg[head_reg];
`ifdef MEM_IQ_BYPASS_EN
    op1_ok  = op1_rdy[head_reg] || op1_wake[head_reg];
    op2_ok  = op2_rdy[head_reg] || op2_wake[head_reg];
    op1_out = op1_rdy[head_reg] ? op1_val[head_reg] : i_wb_data;
    op2_out = op2_rdy[head_reg] ? op2_val[head_reg] : i_wb_data;
`else
    op1_ok  = op1_rdy[head_reg];
    op2_ok  = op2_rdy[head_reg];
    op1_out = op1_val[head_reg];
    op2_out = op2_val[head_reg];
`endif
    issue = valid_reg[head_reg] && op1_ok && (!needs_op2(head_payload.uop) || op2_ok);
  end

  assign o_valid = issue;
  assign o_uop   = head_payload.uop;
  assign o_func  = head_payload.func;
  assign o_imm   = head_payload.imm;
  assign o_addr  = rd_reg[head_reg];
  assign o_op1   = op1_out;
  assign o_op2   = op2_out;

  // Pointer/count/valid next state: flush wipes everything, else apply pop and push.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    valid_next = valid_reg;
    if (i_flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      valid_next = '0;
    end else begin
      if (pop_fire) begin
        valid_next[head_reg] = 1'b0;
        head_next            = head_reg + 1'b1;
      end
      if (enq_fire) begin
        valid_next[tail_reg] = 1'b1;
        tail_next            = tail_reg + 1'b1;
      end
      count_next = count_reg + (DEPTH_W + 1)'(enq_fire) - (DEPTH_W + 1)'(pop_fire);
    end
  end

  // Queue control registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Scoreboard bench for mem_issue_queue: stimulus pushes expected issues, a monitor pops and compares.
// Timing checks adapt to MEM_IQ_BYPASS_EN when that macro is defined for the build.
module tb_mem_issue_queue;
  import mem_iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready;
  logic [6:0]  i_uop;
  logic [9:0]  i_func;
  logic [4:0]  i_addr;
  logic [31:0] i_imm;
  logic        i_op1_rdy, i_op2_rdy;
  logic [4:0]  i_op1_tag, i_op2_tag;
  logic [31:0] i_op1, i_op2;
  logic        i_wb_valid;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_flush;
  logic        o_valid;
  logic [6:0]  o_uop;
  logic [9:0]  o_func;
  logic [4:0]  o_addr;
  logic [31:0] o_op1, o_op2, o_imm;

  typedef struct {
    logic [6:0]  uop;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH_W(3), .WIDTH_REG(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_uop(i_uop), .i_func(i_func), .i_addr(i_addr), .i_imm(i_imm),
    .i_op1_rdy(i_op1_rdy), .i_op2_rdy(i_op2_rdy),
    .i_op1_tag(i_op1_tag), .i_op2_tag(i_op2_tag),
    .i_op1(i_op1), .i_op2(i_op2),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_valid(o_valid), .o_uop(o_uop), .o_func(o_func),
    .o_addr(o_addr), .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm)
  );

  task automatic chk_bit(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every issue seen mid-cycle must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got uop=%h rd=%0d op1=%h expected no issue", o_uop, o_addr, o_op1);
      end else begin
        mon_e = sb.pop_front();
        if ({o_uop, o_addr, o_op1, o_op2, o_imm} !== {mon_e.uop, mon_e.rd, mon_e.op1, mon_e.op2, mon_e.imm}) begin
          miscompares++;
          $display("FAIL issue_rd%0d: got uop=%h rd=%0d op1=%h op2=%h imm=%h expected uop=%h rd=%0d op1=%h op2=%h imm=%h",
                   mon_e.rd, o_uop, o_addr, o_op1, o_op2, o_imm,
                   mon_e.uop, mon_e.rd, mon_e.op1, mon_e.op2, mon_e.imm);
        end
        $display("issue rd=%0d uop=%h op1=%h op2=%h imm=%h", o_addr, o_uop, o_op1, o_op2, o_imm);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000ns");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] uop, input logic [4:0] rd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [31:0] imm);
    exp_t e;
    e.uop = uop; e.rd = rd; e.op1 = op1; e.op2 = op2; e.imm = imm;
    sb.push_back(e);
  endtask

  // Present one dispatch for a single edge.
  task automatic enq(input logic [6:0] uop, input logic [4:0] rd,
                     input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                     input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                     input logic [31:0] imm);
    i_valid = 1'b1; i_uop = uop; i_func = 10'h0; i_addr = rd; i_imm = imm;
    i_op1_rdy = r1; i_op1_tag = t1; i_op1 = v1;
    i_op2_rdy = r2; i_op2_tag = t2; i_op2 = v2;
    tick();
    i_valid = 1'b0;
    $display("enq uop=%h rd=%0d op1_rdy=%b op2_rdy=%b ready=%b", uop, rd, r1, r2, o_ready);
  endtask

  task automatic set_wb(input logic [4:0] addr, input logic [31:0] data);
    i_wb_valid = 1'b1; i_wb_addr = addr; i_wb_data = data;
    #1;
  endtask

  task automatic clear_wb();
    i_wb_valid = 1'b0; i_wb_addr = '0; i_wb_data = '0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    i_uop = '0; i_func = '0; i_addr = '0; i_imm = '0;
    i_op1_rdy = 1'b0; i_op2_rdy = 1'b0; i_op1_tag = '0; i_op2_tag = '0;
    i_op1 = '0; i_op2 = '0;
    clear_wb();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state.
    chk_bit("rst_valid", o_valid, 1'b0);
    chk_bit("rst_ready", o_ready, 1'b1);
    chk_word("rst_op1", o_op1, 32'h0);
    chk_word("rst_addr", 32'(o_addr), 32'h0);

    // Single ready load: issues in the cycle after the enqueue edge.
    push_exp(OPC_LOAD, 5'd7, 32'h100, 32'h0, 32'h4);
    enq(OPC_LOAD, 5'd7, 1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'h0, 32'h4);
    chk_bit("t1_valid", o_valid, 1'b1);
    tick();
    chk_bit("t1_empty", o_valid, 1'b0);
    chk_bit("t1_ready", o_ready, 1'b1);

    // Store waiting on op2 tag 9.
    push_exp(OPC_STORE, 5'd5, 32'h200, 32'hDEAD, 32'h8);
    enq(OPC_STORE, 5'd5, 1'b1, 5'd0, 32'h200, 1'b0, 5'd9, 32'h0, 32'h8);
    chk_bit("t2_wait", o_valid, 1'b0);
    tick();
    chk_bit("t2_wait2", o_valid, 1'b0);
    set_wb(5'd9, 32'hDEAD);
`ifdef MEM_IQ_BYPASS_EN
    chk_bit("t2_bypass", o_valid, 1'b1);
    tick();
    clear_wb();
`else
    chk_bit("t2_wb_cycle", o_valid, 1'b0);
    tick();
    clear_wb();
    chk_bit("t2_issue", o_valid, 1'b1);
    tick();
`endif
    chk_bit("t2_after", o_valid, 1'b0);

    // Blocked head store holds back a ready load.
    push_exp(OPC_STORE, 5'd6, 32'h300, 32'hBEEF, 32'hC);
    push_exp(OPC_LOAD, 5'd8, 32'h400, 32'h0, 32'h10);
    enq(OPC_STORE, 5'd6, 1'b1, 5'd0, 32'h300, 1'b0, 5'd12, 32'h0, 32'hC);
    enq(OPC_LOAD, 5'd8, 1'b1, 5'd0, 32'h400, 1'b1, 5'd0, 32'h0, 32'h10);
    for (int i = 0; i < 4; i++) begin
      chk_bit("t3_blocked", o_valid, 1'b0);
      tick();
    end
    set_wb(5'd12, 32'hBEEF);
`ifndef MEM_IQ_BYPASS_EN
    chk_bit("t3_wb_cycle", o_valid, 1'b0);
    tick();
    clear_wb();
`endif
    chk_bit("t3_store", o_valid, 1'b1);
    tick();
    clear_wb();
    chk_bit("t3_load", o_valid, 1'b1);
    tick();
    chk_bit("t3_after", o_valid, 1'b0);

    // Fill all 8 entries waiting on tag 3; a 9th dispatch is refused.
    for (int i = 0; i < 8; i++) begin
      push_exp(OPC_LOAD, 5'(i + 1), 32'h33, 32'h0, 32'(i));
      enq(OPC_LOAD, 5'(i + 1), 1'b0, 5'd3, 32'h0, 1'b1, 5'd0, 32'h0, 32'(i));
    end
    chk_bit("t4_full", o_ready, 1'b0);
    chk_bit("t4_blocked", o_valid, 1'b0);
    enq(OPC_LOAD, 5'd31, 1'b1, 5'd0, 32'h999, 1'b1, 5'd0, 32'h0, 32'h0);
    chk_bit("t4_still_full", o_ready, 1'b0);
    set_wb(5'd3, 32'h33);
`ifndef MEM_IQ_BYPASS_EN
    chk_bit("t4_wb_cycle", o_valid, 1'b0);
    tick();
    clear_wb();
`endif
    for (int i = 0; i < 8; i++) begin
      chk_bit("t4_burst_valid", o_valid, 1'b1);
      chk_bit("t4_burst_ready", o_ready, (i != 0));
      tick();
      clear_wb();
    end
    chk_bit("t4_empty", o_valid, 1'b0);

    // Flush with a concurrent dispatch: queue empties, the dispatch is dropped.
    for (int i = 0; i < 5; i++)
      enq(OPC_LOAD, 5'(10 + i), 1'b0, 5'd4, 32'h0, 1'b1, 5'd0, 32'h0, 32'h0);
    chk_bit("t5_pending", o_valid, 1'b0);
    i_flush = 1'b1;
    enq(OPC_LOAD, 5'd20, 1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h0, 32'h0);
    i_flush = 1'b0;
    chk_bit("t5_valid", o_valid, 1'b0);
    chk_bit("t5_ready", o_ready, 1'b1);
    set_wb(5'd4, 32'h44);
    chk_bit("t5_no_wake", o_valid, 1'b0);
    tick();
    clear_wb();
    chk_bit("t5_no_wake2", o_valid, 1'b0);
    push_exp(OPC_LOAD, 5'd21, 32'h55, 32'h0, 32'h0);
    enq(OPC_LOAD, 5'd21, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h0, 32'h0);
    chk_bit("t5_restart", o_valid, 1'b1);
    tick();
    chk_bit("t5_after", o_valid, 1'b0);

    // 20 back-to-back ready loads: continuous issue across two pointer wraps.
    for (int i = 1; i <= 20; i++) begin
      push_exp(OPC_LOAD, 5'(i), 32'h1000 + 32'(i), 32'h0, 32'(i));
      enq(OPC_LOAD, 5'(i), 1'b1, 5'd0, 32'h1000 + 32'(i), 1'b1, 5'd0, 32'h0, 32'(i));
      chk_bit("t6_stream", o_valid, 1'b1);
    end
    tick();
    chk_bit("t6_after", o_valid, 1'b0);

    tick();
    chk_word("sb_drain", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
